// File: rtl/dma_sample_arbiter_pkg.sv
// dma_sample_arbiter_pkg: shared FSM state encoding and default DMA widths for the sample arbiter.
package dma_sample_arbiter_pkg;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam int DMA_ADDR_W = 16;
  localparam int DMA_DATA_W = 16;
endpackage

// File: rtl/dma_sample_arbiter_if.sv
// dma_sample_arbiter_if: channel request side and memory DMA side of the sample arbiter.
//   master = arbiter (drives req_data/req_rdy/startDMA/addrDMA/busy/timeout_err)
//   slave  = environment (drives req_start/req_addr/fromMemDMA/rdyDMA)
interface dma_sample_arbiter_if
  import dma_sample_arbiter_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int DATA_W = DMA_DATA_W
);
  logic [NUM_CH-1:0]        req_start;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0]        req_data;
  logic [NUM_CH-1:0]        req_rdy;
  logic                     startDMA;
  logic [ADDR_W-1:0]        addrDMA;
  logic [DATA_W-1:0]        fromMemDMA;
  logic                     rdyDMA;
  logic                     busy;
  logic                     timeout_err;
  modport master (
    input  req_start, req_addr, fromMemDMA, rdyDMA,
    output req_data, req_rdy, startDMA, addrDMA, busy, timeout_err
  );
  modport slave (
    output req_start, req_addr, fromMemDMA, rdyDMA,
    input  req_data, req_rdy, startDMA, addrDMA, busy, timeout_err
  );
endinterface

// File: rtl/dma_sample_arbiter_rr_pick.sv
// dma_sample_arbiter_rr_pick: combinational round-robin picker; first pending channel after last.
//   pend     pending request bits
//   last     index of the previously granted channel
//   any      at least one channel pending
//   pick_oh  one-hot winner, pick_idx its index
module dma_sample_arbiter_rr_pick #(
  parameter int NUM_CH = 3,
  parameter int IW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] pend,
  input  logic [IW-1:0]     last,
  output logic              any,
  output logic [NUM_CH-1:0] pick_oh,
  output logic [IW-1:0]     pick_idx
);
  // Scan from farthest to nearest so the nearest pending channel after last is the final assignment.
  always_comb begin
    any = |pend;
    pick_idx = '0;
    for (int k = NUM_CH; k >= 1; k--)
      if (pend[(int'(last) + k) % NUM_CH]) pick_idx = IW'((int'(last) + k) % NUM_CH);
    pick_oh = any ? NUM_CH'(1) << pick_idx : '0;
  end
endmodule

// File: rtl/dma_sample_arbiter.sv
// dma_sample_arbiter: round-robin merge of per-channel sample DMA reads onto one memory port, with timeout.
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   request strobes/addresses in, data/ready strobes out, memory start/address out, memory data/ready in
module dma_sample_arbiter
  import dma_sample_arbiter_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = DMA_ADDR_W,
  parameter int DATA_W  = DMA_DATA_W,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  dma_sample_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_CH);
  logic [NUM_CH-1:0] pend, pick_oh, grant;
  logic [ADDR_W-1:0] addr_q [NUM_CH];
  logic [0:0]        state;
  logic [7:0]        cnt;
  logic [IW-1:0]     last, cur, pick_idx;
  logic              any;
  dma_sample_arbiter_rr_pick #(.NUM_CH(NUM_CH), .IW(IW)) u_pick (
    .pend(pend), .last(last), .any(any), .pick_oh(pick_oh), .pick_idx(pick_idx)
  );
  assign grant = (state == IDLE) ? pick_oh : '0;
  assign bus.busy = (state != IDLE) || (|pend);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= '0;
      for (int i = 0; i < NUM_CH; i++) addr_q[i] <= '0;
      state <= IDLE;
      cnt <= '0;
      last <= IW'(NUM_CH - 1);
      cur <= '0;
      bus.req_data <= '0;
      bus.req_rdy <= '0;
      bus.startDMA <= 1'b0;
      bus.addrDMA <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      // A fresh strobe beats the grant's clear, so a re-request during the grant stays pending.
      pend <= (pend & ~grant) | bus.req_start;
      for (int i = 0; i < NUM_CH; i++)
        if (bus.req_start[i]) addr_q[i] <= bus.req_addr[i*ADDR_W +: ADDR_W];
      bus.startDMA <= 1'b0;
      bus.req_rdy <= '0;
      bus.timeout_err <= 1'b0;
      if (state == IDLE) begin
        if (any) begin
          cur <= pick_idx;
          last <= pick_idx;
          bus.addrDMA <= addr_q[pick_idx];
          bus.startDMA <= 1'b1;
          cnt <= '0;
          state <= WAIT;
        end
      end else if (bus.rdyDMA) begin
        bus.req_data <= bus.fromMemDMA;
        bus.req_rdy <= NUM_CH'(1) << cur;
        state <= IDLE;
      end else if (cnt == 8'(TIMEOUT)) begin
        bus.req_data <= {DATA_W{1'b0}};
        bus.req_rdy <= NUM_CH'(1) << cur;
        bus.timeout_err <= 1'b1;
        state <= IDLE;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_dma_sample_arbiter.sv
// tb_dma_sample_arbiter: directed and random stimulus checked against a behavioural arbiter model.
module tb_dma_sample_arbiter;
  localparam int NUM_CH = 3;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 255;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  dma_sample_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(AW), .DATA_W(DW)) bus ();
  dma_sample_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  int errors = 0;
  int checks = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Behavioural model: pending set with latest address, one outstanding read, cycle-accurate outputs.
  bit m_pend [NUM_CH];
  logic [AW-1:0] m_addr [NUM_CH];
  int m_last, m_cur, m_age;
  bit m_wait;
  bit e_start, e_terr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [NUM_CH-1:0] e_rdy;
  task automatic model_reset();
    foreach (m_pend[i]) begin
      m_pend[i] = 0;
      m_addr[i] = '0;
    end
    m_last = NUM_CH - 1;
    m_cur = 0;
    m_age = 0;
    m_wait = 0;
    e_start = 0;
    e_terr = 0;
    e_addr = '0;
    e_data = '0;
    e_rdy = '0;
  endtask
  function automatic bit model_busy();
    bit b = m_wait;
    foreach (m_pend[i]) b |= m_pend[i];
    return b;
  endfunction
  task automatic model_step();
    int g = -1;
    e_start = 0;
    e_terr = 0;
    e_rdy = '0;
    if (!m_wait) begin
      for (int k = 1; k <= NUM_CH && g < 0; k++)
        if (m_pend[(m_last + k) % NUM_CH]) g = (m_last + k) % NUM_CH;
      if (g >= 0) begin
        e_start = 1;
        e_addr = m_addr[g];
        m_cur = g;
        m_last = g;
        m_wait = 1;
        m_age = 0;
        m_pend[g] = 0;
      end
    end else if (bus.rdyDMA) begin
      e_data = bus.fromMemDMA;
      e_rdy = NUM_CH'(1) << m_cur;
      m_wait = 0;
    end else if (m_age == TO) begin
      e_data = '0;
      e_rdy = NUM_CH'(1) << m_cur;
      e_terr = 1;
      m_wait = 0;
    end else begin
      m_age++;
    end
    for (int i = 0; i < NUM_CH; i++)
      if (bus.req_start[i]) begin
        m_pend[i] = 1;
        m_addr[i] = bus.req_addr[i*AW +: AW];
      end
  endtask
  initial model_reset();
  always @(negedge rst) model_reset();
  always @(posedge clk) begin
    if (!rst) model_reset();
    else model_step();
  end
  always @(negedge clk) begin
    check("startDMA", {31'd0, bus.startDMA}, {31'd0, e_start});
    if (e_start) check("addrDMA", {16'd0, bus.addrDMA}, {16'd0, e_addr});
    check("req_rdy", {29'd0, bus.req_rdy}, {29'd0, e_rdy});
    if (|e_rdy) check("req_data", {16'd0, bus.req_data}, {16'd0, e_data});
    check("timeout_err", {31'd0, bus.timeout_err}, {31'd0, e_terr});
    check("busy", {31'd0, bus.busy}, {31'd0, model_busy()});
  end
  int c40 = 0, c41 = 0, t3_viol = 0, t3_ch1 = 0, prev_ch = -1;
  bit t3_on = 0;
  always @(negedge clk) begin
    if (bus.startDMA) begin
      if (bus.addrDMA == 16'h0040) c40++;
      if (bus.addrDMA == 16'h0041) c41++;
      if (t3_on) begin
        if (prev_ch == 1 && bus.addrDMA[15:12] == 4'd1) t3_viol++;
        if (bus.addrDMA[15:12] == 4'd1) t3_ch1++;
        prev_ch = int'(bus.addrDMA[15:12]);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask
  task automatic strobe(input int ch, input logic [AW-1:0] a);
    bus.req_start[ch] = 1'b1;
    bus.req_addr[ch*AW +: AW] = a;
    tick();
    bus.req_start = '0;
  endtask
  task automatic wait_start();
    int n = 0;
    while (!bus.startDMA && n < 100) begin
      tick();
      n++;
    end
    check("start_seen", {31'd0, bus.startDMA}, 32'd1);
  endtask
  task automatic serve(input logic [AW-1:0] a, input int ch, input logic [DW-1:0] d, input int lat);
    wait_start();
    check("grant_addr", {16'd0, bus.addrDMA}, {16'd0, a});
    repeat (lat) tick();
    bus.rdyDMA = 1'b1;
    bus.fromMemDMA = d;
    tick();
    bus.rdyDMA = 1'b0;
    check("serve_rdy", {29'd0, bus.req_rdy}, 32'd1 << ch);
    check("serve_data", {16'd0, bus.req_data}, {16'd0, d});
  endtask
  initial begin
    int n;
    bus.req_start = '0;
    bus.req_addr = '0;
    bus.fromMemDMA = '0;
    bus.rdyDMA = 1'b0;
    do_reset();
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_start", {31'd0, bus.startDMA}, 32'd0);
    check("rst_rdy", {29'd0, bus.req_rdy}, 32'd0);
    check("rst_addr", {16'd0, bus.addrDMA}, 32'd0);
    // single read latency
    strobe(0, 16'h1234);
    check("t1_c1_start", {31'd0, bus.startDMA}, 32'd0);
    check("t1_c1_busy", {31'd0, bus.busy}, 32'd1);
    tick();
    check("t1_c2_start", {31'd0, bus.startDMA}, 32'd1);
    check("t1_c2_addr", {16'd0, bus.addrDMA}, 32'h1234);
    repeat (3) tick();
    bus.rdyDMA = 1'b1;
    bus.fromMemDMA = 16'hBEEF;
    tick();
    bus.rdyDMA = 1'b0;
    check("t1_rdy", {29'd0, bus.req_rdy}, 32'b001);
    check("t1_data", {16'd0, bus.req_data}, 32'hBEEF);
    tick();
    check("t1_rdy_low", {29'd0, bus.req_rdy}, 32'd0);
    // simultaneous requests from a fresh reset
    do_reset();
    bus.req_start = 3'b111;
    bus.req_addr = {16'h0030, 16'h0020, 16'h0010};
    tick();
    bus.req_start = '0;
    serve(16'h0010, 0, 16'hA000, 1);
    serve(16'h0020, 1, 16'hA001, 2);
    serve(16'h0030, 2, 16'hA002, 1);
    // fairness under continuous requests
    t3_on = 1;
    prev_ch = -1;
    for (int c = 0; c < 50; c++) begin
      for (int i = 0; i < NUM_CH; i++) bus.req_addr[i*AW +: AW] = {4'(i), 12'($urandom)};
      bus.req_start = 3'b111;
      bus.rdyDMA = ($urandom_range(0, 2) == 0);
      bus.fromMemDMA = 16'($urandom);
      tick();
    end
    bus.req_start = '0;
    repeat (40) begin
      bus.rdyDMA = ($urandom_range(0, 1) == 0);
      bus.fromMemDMA = 16'($urandom);
      tick();
    end
    bus.rdyDMA = 1'b0;
    t3_on = 0;
    tick();
    check("t3_ch1_twice", t3_viol, 0);
    check("t3_ch1_served", {31'd0, t3_ch1 > 0}, 32'd1);
    // timeout and recovery
    strobe(0, 16'h0500);
    wait_start();
    n = 0;
    while (bus.req_rdy == '0 && n < 400) begin
      tick();
      n++;
    end
    check("t4_cycles", n, 256);
    check("t4_rdy", {29'd0, bus.req_rdy}, 32'b001);
    check("t4_data", {16'd0, bus.req_data}, 32'd0);
    check("t4_terr", {31'd0, bus.timeout_err}, 32'd1);
    tick();
    check("t4_terr_low", {31'd0, bus.timeout_err}, 32'd0);
    strobe(1, 16'h0600);
    serve(16'h0600, 1, 16'h5A5A, 2);
    // reset during a read
    strobe(1, 16'h0700);
    wait_start();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    bus.rdyDMA = 1'b1;
    bus.fromMemDMA = 16'hFFFF;
    tick();
    bus.rdyDMA = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("t5_rdy", {29'd0, bus.req_rdy}, 32'd0);
      check("t5_data", {16'd0, bus.req_data}, 32'd0);
      check("t5_busy", {31'd0, bus.busy}, 32'd0);
      check("t5_start", {31'd0, bus.startDMA}, 32'd0);
      tick();
    end
    // latest address wins on a re-strobe before grant
    strobe(0, 16'h0800);
    wait_start();
    c40 = 0;
    c41 = 0;
    strobe(2, 16'h0040);
    strobe(2, 16'h0041);
    bus.rdyDMA = 1'b1;
    bus.fromMemDMA = 16'h0001;
    tick();
    bus.rdyDMA = 1'b0;
    serve(16'h0041, 2, 16'h4141, 1);
    repeat (10) tick();
    check("t6_reads_40", c40, 0);
    check("t6_reads_41", c41, 1);
    // random traffic against the model
    repeat (600) begin
      for (int i = 0; i < NUM_CH; i++) begin
        bus.req_start[i] = ($urandom_range(0, 3) == 0);
        bus.req_addr[i*AW +: AW] = 16'($urandom);
      end
      bus.rdyDMA = ($urandom_range(0, 2) == 0);
      bus.fromMemDMA = 16'($urandom);
      tick();
    end
    bus.req_start = '0;
    repeat (40) begin
      bus.rdyDMA = ($urandom_range(0, 1) == 0);
      bus.fromMemDMA = 16'($urandom);
      tick();
    end
    bus.rdyDMA = 1'b0;
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
